fsm_peatonal: RTL and testbench
===============================

// Module: fsm_peatonal
// PURPOSE
//  Phase controller for the pedestrian crossing and protected-turn signal. It is the stage
//  directly upstream of the two-lamp light drivers.
//  Latches a pedestrian push-button request and sequences the phases
//  TURN -> CLEAR -> PED -> BLINK -> CLEAR2 -> VEH.
//  Outputs are 2-bit light codes for the pedestrian and turn light drivers: RED=2'b00,
//  GREEN=2'b10, OFF=2'b11. It also outputs a vehicle-go flag for the main signal.
// PARAMETERS
//  CLK_DIV    50_000_000  clk cycles per 1 s tick, >=2
//  T_MIN_VEH  10          min VEH dwell in ticks, 1..255
//  T_TURN     5           TURN dwell in ticks, 1..255
//  T_CLEAR    2           CLEAR/CLEAR2 all-red dwell in ticks, 1..255
//  T_PED      8           PED steady-green dwell in ticks, 1..255
//  T_BLINK    4           BLINK dwell in ticks, 1..255
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  ped_req      in   1  raw push-button, asynchronous, level
//  ped_light    out  2  pedestrian light code (RED/GREEN/OFF)
//  turn_light   out  2  turn light code (RED/GREEN)
//  veh_go       out  1  1 = main vehicle flow may proceed
//  req_pending  out  1  1 = pedestrian request latched, not yet served
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, any time including mid-phase):
//   - state=VEH, ped_light=00, turn_light=00, veh_go=1, req_pending=0.
//   - Prescaler, tick counter and sync flops cleared.
//  Input conditioning:
//   - ped_req passes through a 2-FF synchroniser (s1,s2) and a rise detector (s2 & ~s2_d).
//   - One request per press; a held button never re-triggers.
//  Request latch:
//   - req_pending is set the edge after a detected rise, in states VEH/TURN/CLEAR/CLEAR2.
//   - Rises in PED/BLINK are ignored.
//   - req_pending is cleared on entry to PED.
//  Timing:
//   - Prescaler counts 0..CLK_DIV-1; tick=1 for one cycle at CLK_DIV-1.
//   - The 8-bit tick counter increments on tick.
//   - Both counters clear on every state transition, so dwell N = exactly N*CLK_DIV cycles.
//   - In VEH the tick counter saturates at T_MIN_VEH.
//  States and outputs (registered, change on the same edge as state):
//   VEH    ped=00 turn=00 veh_go=1
//          -> TURN on the edge where tickcnt==T_MIN_VEH && req_pending.
//          -> Waits indefinitely with no request.
//   TURN   ped=00 turn=10 veh_go=0  -> CLEAR after T_TURN ticks
//   CLEAR  ped=00 turn=00 veh_go=0  -> PED after T_CLEAR ticks
//   PED    ped=10 turn=00 veh_go=0  -> BLINK after T_PED ticks
//   BLINK  ped=11 on even tickcnt, 10 on odd; turn=00 veh_go=0  -> CLEAR2 after T_BLINK ticks
//   CLEAR2 ped=00 turn=00 veh_go=0  -> VEH after T_CLEAR ticks
//  Latency:
//   - ped_req high sampled at edge k -> req_pending=1 at edge k+3.
//   - If min dwell is already met, state=TURN at edge k+4.
//  Safety:
//   - ped GREEN/OFF and turn GREEN are never asserted together.
//   - veh_go=1 only in VEH.
//   - Illegal state encoding -> VEH with reset outputs next edge.
//  Downstream drivers register the codes: lamps lag ped_light/turn_light by 1 cycle.
// TESTING (CLK_DIV=4, T_MIN_VEH=3, T_TURN=2, T_CLEAR=1, T_PED=3, T_BLINK=4)
//  1. Reset, ped_req=0 for 200 cycles -> ped=00 turn=00 veh_go=1 req_pending=0 throughout.
//  2. Pulse ped_req 3 cycles at cycle 2 after reset -> req_pending=1; full sequence:
//     - TURN at cycle 12, turn=10 for 8 cycles; CLEAR 4; PED ped=10 for 12 cycles.
//     - BLINK ped=11,10,11,10 for 4 cycles each; CLEAR2 4; then VEH with veh_go=1, req_pending=0.
//  3. ped_req rise at cycle 50 of idle VEH -> req_pending=1 at edge +3, state=TURN at edge +4.
//  4. Press during PED and during BLINK -> ignored, return to VEH and stay.
//     Press during CLEAR2 -> latched, next TURN exactly 12 cycles after VEH entry.
//  5. Hold ped_req=1 for 300 cycles -> exactly one crossing sequence, then VEH, req_pending=0.
//  6. Assert rst_n=0 mid-BLINK, between clock edges -> outputs 00/00/veh_go=1 immediately.
//     After release, no crossing occurs without a new press.

Source files
------------

// File: rtl/fsm_peatonal.sv
// Pedestrian crossing / protected-turn phase controller.
// Latches a synchronised push-button request and sequences TURN -> CLEAR -> PED -> BLINK -> CLEAR2 -> VEH.
module fsm_peatonal #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int T_MIN_VEH = 10,
  parameter int T_TURN    = 5,
  parameter int T_CLEAR   = 2,
  parameter int T_PED     = 8,
  parameter int T_BLINK   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  output logic [1:0] ped_light,
  output logic [1:0] turn_light,
  output logic       veh_go,
  output logic       req_pending
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [7:0] MIN_VEH    = 8'(T_MIN_VEH);
  localparam logic [7:0] MIN_VEH_M1 = 8'(T_MIN_VEH - 1);
  localparam logic [7:0] TURN_LAST  = 8'(T_TURN - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(T_CLEAR - 1);
  localparam logic [7:0] PED_LAST   = 8'(T_PED - 1);
  localparam logic [7:0] BLINK_LAST = 8'(T_BLINK - 1);

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b10;
  localparam logic [1:0] OFF   = 2'b11;

  typedef enum logic [2:0] {
    VEH    = 3'd0,
    TURN   = 3'd1,
    CLEAR  = 3'd2,
    PED    = 3'd3,
    BLINK  = 3'd4,
    CLEAR2 = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [7:0]    tickcnt, tickcnt_nxt;
  logic          s1, s2, s2_d, rise_q;
  logic          tick, transition, pend_nxt;
  logic [1:0]    ped_nxt, turn_nxt;
  logic          veh_nxt;

  assign tick = (presc == PRESC_MAX);

  // Next state, counters and request latch.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    case (state)
      // Min dwell counts as met on the very edge the counter reaches it.
      VEH:    if (req_pending && ((tickcnt == MIN_VEH) || (tick && tickcnt == MIN_VEH_M1)))
                state_nxt = TURN;
      TURN:   if (tick && tickcnt == TURN_LAST)  state_nxt = CLEAR;
      CLEAR:  if (tick && tickcnt == CLEAR_LAST) state_nxt = PED;
      PED:    if (tick && tickcnt == PED_LAST)   state_nxt = BLINK;
      BLINK:  if (tick && tickcnt == BLINK_LAST) state_nxt = CLEAR2;
      CLEAR2: if (tick && tickcnt == CLEAR_LAST) state_nxt = VEH;
      default: state_nxt = VEH;
    endcase

    transition = (state_nxt != state);

    presc_nxt = (transition || tick) ? '0 : presc + 1'b1;

    tickcnt_nxt = tickcnt;
    if (transition)
      tickcnt_nxt = '0;
    else if (tick && !(state == VEH && tickcnt == MIN_VEH))
      tickcnt_nxt = tickcnt + 8'd1;

    pend_nxt = req_pending;
    if (state_nxt == PED && state != PED)
      pend_nxt = 1'b0;
    else if (rise_q && (state inside {VEH, TURN, CLEAR, CLEAR2}))
      pend_nxt = 1'b1;
  end

  // Light codes are decoded from the upcoming state so they register on the same edge.
  always_comb begin
    ped_nxt  = RED;
    turn_nxt = RED;
    veh_nxt  = 1'b0;
    case (state_nxt)
      VEH:     veh_nxt  = 1'b1;
      TURN:    turn_nxt = GREEN;
      PED:     ped_nxt  = GREEN;
      BLINK:   ped_nxt  = tickcnt_nxt[0] ? GREEN : OFF;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: every flop here is cleared by the asynchronous reset; there is no memory array to exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= VEH;
      presc       <= '0;
      tickcnt     <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s2_d        <= 1'b0;
      rise_q      <= 1'b0;
      req_pending <= 1'b0;
      ped_light   <= RED;
      turn_light  <= RED;
      veh_go      <= 1'b1;
    end else begin
      s1          <= ped_req;
      s2          <= s1;
      s2_d        <= s2;
      rise_q      <= s2 & ~s2_d;
      state       <= state_nxt;
      presc       <= presc_nxt;
      tickcnt     <= tickcnt_nxt;
      req_pending <= pend_nxt;
      ped_light   <= ped_nxt;
      turn_light  <= turn_nxt;
      veh_go      <= veh_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_peatonal.sv
// Directed bench for fsm_peatonal: expected light codes are queued per clock edge
// and compared against the DUT outputs just after each edge.
module tb_fsm_peatonal;

  localparam int CLK_DIV   = 4;
  localparam int T_MIN_VEH = 3;
  localparam int T_TURN    = 2;
  localparam int T_CLEAR   = 1;
  localparam int T_PED     = 3;
  localparam int T_BLINK   = 4;

  // Phase boundaries in clock edges, counted from the TURN entry edge.
  localparam int END_TURN   = T_TURN * CLK_DIV;                 // 8
  localparam int END_CLEAR  = END_TURN + T_CLEAR * CLK_DIV;     // 12
  localparam int END_PED    = END_CLEAR + T_PED * CLK_DIV;      // 24
  localparam int END_BLINK  = END_PED + T_BLINK * CLK_DIV;      // 40
  localparam int END_CLEAR2 = END_BLINK + T_CLEAR * CLK_DIV;    // 44
  localparam int VEH_MIN    = T_MIN_VEH * CLK_DIV;              // 12

  logic       clk, rst_n, ped_req;
  logic [1:0] ped_light, turn_light;
  logic       veh_go, req_pending;

  fsm_peatonal #(
    .CLK_DIV(CLK_DIV), .T_MIN_VEH(T_MIN_VEH), .T_TURN(T_TURN),
    .T_CLEAR(T_CLEAR), .T_PED(T_PED), .T_BLINK(T_BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req),
    .ped_light(ped_light), .turn_light(turn_light),
    .veh_go(veh_go), .req_pending(req_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic push(input string tag, input logic [1:0] ped, input logic [1:0] turn,
                      input logic veh, input logic pend);
    sb_t e;
    e.tag = tag;
    e.exp = {ped, turn, veh, pend};
    sb_q.push_back(e);
  endtask

  task automatic check();
    sb_t        e;
    logic [5:0] obs;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed nothing queued, required one entry");
      return;
    end
    e   = sb_q.pop_front();
    obs = {ped_light, turn_light, veh_go, req_pending};
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed ped/turn/veh/pend=%b required %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_veh(input string tag, input int n, input logic pend);
    for (int i = 0; i < n; i++) begin
      push(tag, 2'b00, 2'b00, 1'b1, pend);
      step();
      check();
    end
  endtask

  // A press raised after crossing edge p is latched only if its detected rise lands in CLEAR2.
  function automatic logic latched_at(input int p, input int i);
    return (p >= 0) && (p + 3 >= END_BLINK) && (i >= p + 4);
  endfunction

  // Expects crossing edges 0..n-1 (edge 0 = TURN entry); pa/pb raise ped_req for 3 cycles.
  task automatic run_crossing(input string tag, input int pa, input int pb, input int n);
    logic [1:0] ped, turn;
    logic       pend;
    for (int i = 0; i < n; i++) begin
      turn = 2'b00;
      ped  = 2'b00;
      if (i < END_TURN)        turn = 2'b10;
      else if (i < END_CLEAR)  ped  = 2'b00;
      else if (i < END_PED)    ped  = 2'b10;
      else if (i < END_BLINK)  ped  = (((i - END_PED) / CLK_DIV) % 2 == 0) ? 2'b11 : 2'b10;
      pend = (i < END_CLEAR) || latched_at(pa, i) || latched_at(pb, i);
      push(tag, ped, turn, 1'b0, pend);
      step();
      check();
      if (i == pa || i == pb) ped_req = 1'b1;
      if ((pa >= 0 && i == pa + 3) || (pb >= 0 && i == pb + 3)) ped_req = 1'b0;
    end
  endtask

  // Press from idle VEH with min dwell met: pending at edge k+3, TURN at k+4.
  task automatic press_from_idle(input string tag, input logic hold);
    ped_req = 1'b1;
    run_veh(tag, 3, 1'b0);
    if (!hold) ped_req = 1'b0;
    run_veh(tag, 1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of stimulus, required finish within 100000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n   = 1'b0;
    ped_req = 1'b0;

    // 1: reset values, then long idle with no request
    repeat (3) @(posedge clk);
    #1;
    push("t1_reset", 2'b00, 2'b00, 1'b1, 1'b0);
    check();
    @(negedge clk) rst_n = 1'b1;
    run_veh("t1_idle", 200, 1'b0);

    // 2: 3-cycle press two cycles after reset release; TURN lands on edge 12
    @(negedge clk) rst_n = 1'b0;
    #1;
    push("t2_reset", 2'b00, 2'b00, 1'b1, 1'b0);
    check();
    @(negedge clk) rst_n = 1'b1;
    run_veh("t2_pre", 2, 1'b0);
    ped_req = 1'b1;
    run_veh("t2_sync", 3, 1'b0);
    ped_req = 1'b0;
    run_veh("t2_pend", VEH_MIN - 6, 1'b1);
    run_crossing("t2_seq", -1, -1, END_CLEAR2);
    run_veh("t2_back", 10, 1'b0);

    // 3/4: press after ~50 idle cycles; presses in PED and BLINK are ignored
    run_veh("t3_idle", 40, 1'b0);
    press_from_idle("t3_latency", 1'b0);
    run_crossing("t4_ignore", 14, 28, END_CLEAR2);
    run_veh("t4_stay", 40, 1'b0);

    // 4: press in CLEAR2 is latched; next TURN exactly VEH_MIN cycles after VEH entry
    press_from_idle("t4_start", 1'b0);
    run_crossing("t4_clr2", 37, -1, END_CLEAR2);
    run_veh("t4_relatch", VEH_MIN, 1'b1);
    run_crossing("t4_second", -1, -1, END_CLEAR2);
    run_veh("t4_settle", 20, 1'b0);

    // 5: held button gives exactly one crossing over 300 cycles
    press_from_idle("t5_hold_start", 1'b1);
    run_crossing("t5_seq", -1, -1, END_CLEAR2);
    run_veh("t5_hold", 300 - 4 - END_CLEAR2, 1'b0);
    ped_req = 1'b0;
    run_veh("t5_after", 20, 1'b0);

    // 6: asynchronous reset mid-BLINK, between clock edges
    press_from_idle("t6_start", 1'b0);
    run_crossing("t6_pre", -1, -1, 30);
    #2 rst_n = 1'b0;
    #1;
    push("t6_async_reset", 2'b00, 2'b00, 1'b1, 1'b0);
    check();
    @(negedge clk) rst_n = 1'b1;
    run_veh("t6_after", 100, 1'b0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
